// File: rtl/tinker_arb_pkg.sv
// Shared types for the Tinker memory arbiter.
// Holds FSM state, transaction owner and watchdog width.
package tinker_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } arb_owner_t;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Fetch, data and memory-side bus bundle for the arbiter.
// Modports: slave = arbiter view, master = requesters plus memory.
interface tinker_mem_arbiter_if #(
    parameter int ADDR_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [63:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/tinker_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// Ports: if_req, d_req, last_owner in; win out. Macro: TINKER_ARB_RR_EN.
module tinker_arb_pick
    import tinker_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output arb_owner_t win
);

`ifdef TINKER_ARB_RR_EN
    // On contention, serve whoever was not served at the last issue.
    always_comb begin
        win = OWN_NONE;
        unique case (1'b1)
            (d_req && if_req):
                win = (last_owner == OWN_DATA) ?
                      OWN_FETCH : OWN_DATA;
            (d_req && !if_req): win = OWN_DATA;
            (!d_req && if_req): win = OWN_FETCH;
            default:            win = OWN_NONE;
        endcase
    end
`else
    // Fixed priority: data always beats fetch.
    logic unused_last;
    assign unused_last = ^last_owner;

    always_comb begin
        win = OWN_NONE;
        unique case (1'b1)
            d_req:              win = OWN_DATA;
            (!d_req && if_req): win = OWN_FETCH;
            default:            win = OWN_NONE;
        endcase
    end
`endif

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares one 64-bit memory port between fetch and load/store.
// Ports: clk, reset (async, high), bus (slave), err. Macro: TINKER_ARB_RR_EN.
module tinker_mem_arbiter
    import tinker_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    tinker_mem_arbiter_if.slave  bus,
    output logic                 err
);

    localparam logic [WDOG_W-1:0] TO_V = WDOG_W'(TIMEOUT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        last_q,  last_d;
    logic [WDOG_W-1:0] wdog_q,  wdog_d;
    logic              err_q,   err_d;

    arb_owner_t        win;
    logic              rsp;
    logic              issue_pt;
    logic [WDOG_W-1:0] wdog_inc;
    logic [ADDR_W-1:0] d_addr_s;
    logic [ADDR_W-1:0] if_addr_s;

    assign d_addr_s  = bus.d_addr;
    assign if_addr_s = bus.if_addr;
    assign err       = err_q;

    tinker_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .last_owner (last_q),
        .win        (win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            last_q  <= OWN_FETCH;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the issue point so outputs drop at once.
    assign rsp      = (state_q == ARB_WAIT) && bus.mem_rvalid;
    assign issue_pt = !reset &&
                      ((state_q == ARB_IDLE) || rsp);
    assign wdog_inc = wdog_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        wdog_d        = wdog_q;
        err_d         = err_q;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        // Completion: memory is big-endian, fetch takes the upper word.
        if (rsp) begin
            if (owner_q == OWN_FETCH) begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_rdata[63:32];
            end else if (owner_q == OWN_DATA) begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.mem_rdata;
            end
        end

        if (issue_pt) begin
            if (win != OWN_NONE) begin
                state_d    = ARB_WAIT;
                owner_d    = win;
                last_d     = win;
                wdog_d     = '0;
                bus.mem_en = 1'b1;
                if (win == OWN_DATA) begin
                    bus.d_gnt     = 1'b1;
                    bus.mem_we    = bus.d_we;
                    bus.mem_addr  = d_addr_s;
                    bus.mem_wdata = bus.d_wdata;
                end else begin
                    bus.if_gnt   = 1'b1;
                    bus.mem_addr = if_addr_s;
                end
            end else begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
                wdog_d  = '0;
            end
        end else if (state_q == ARB_WAIT) begin
            // Stalled cycle; abort once TIMEOUT of them have passed.
            wdog_d = wdog_inc;
            if (wdog_inc == TO_V) begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
                wdog_d  = '0;
                err_d   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Directed self-checking bench for tinker_mem_arbiter.
// Runs with TIMEOUT=4; honours TINKER_ARB_RR_EN for arbitration order.
module tb_tinker_mem_arbiter;

    logic clk;
    logic reset;
    logic err;
    int   checks;
    int   errors;

    tinker_mem_arbiter_if #(.ADDR_W(32)) bus ();

    tinker_mem_arbiter #(
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic test_reset;
        logic [6:0] flags;
        reset = 1'b1;
        clear_inputs();
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        tick();
        @(negedge clk);
        flags = {bus.if_gnt, bus.if_rvalid, bus.d_gnt,
                 bus.d_rvalid, bus.mem_en, bus.mem_we, err};
        checks++;
        if (flags !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0", flags);
        end
        checks++;
        if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem got %h/%h want 0",
                     bus.mem_addr, bus.mem_wdata);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got en=%b err=%b want 0",
                     bus.mem_en, err);
        end
    endtask

    task automatic test_fetch;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h2000;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1 || bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL fetch_gnt got gnt=%b en=%b want 1/1",
                     bus.if_gnt, bus.mem_en);
        end
        checks++;
        if (bus.mem_addr !== 32'h2000 || bus.mem_we !== 1'b0 ||
            bus.mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL fetch_issue got a=%h we=%b wd=%h want 2000/0/0",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        tick();
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fetch_rsp got v=%b d=%h want 1/12345678",
                     bus.if_rvalid, bus.if_rdata);
        end
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_side got dv=%b en=%b want 0/0",
                     bus.d_rvalid, bus.mem_en);
        end
        tick();
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'd0) begin
            errors++;
            $display("FAIL fetch_quiet got v=%b d=%h want 0/0",
                     bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_store;
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b1 ||
            bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL store_gnt got g=%b en=%b we=%b want 1/1/1",
                     bus.d_gnt, bus.mem_en, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 32'h100 ||
            bus.mem_wdata !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL store_issue got a=%h wd=%h want 100/deadbeef00000001",
                     bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'd0;
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_ack got dv=%b iv=%b want 1/0",
                     bus.d_rvalid, bus.if_rvalid);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_priority;
        logic exp_d [4];
`ifdef TINKER_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h300;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 64'h1000 + 64'(i);
            end
            if (i == 4) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (bus.d_gnt !== exp_d[i] ||
                    bus.if_gnt !== !exp_d[i]) begin
                    errors++;
                    $display("FAIL prio_gnt%0d got d=%b f=%b want d=%b",
                             i, bus.d_gnt, bus.if_gnt, exp_d[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (bus.d_rvalid !== exp_d[i-1] ||
                    bus.if_rvalid !== !exp_d[i-1]) begin
                    errors++;
                    $display("FAIL prio_rsp%0d got d=%b f=%b want d=%b",
                             i, bus.d_rvalid, bus.if_rvalid, exp_d[i-1]);
                end
            end
            tick();
        end
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h800;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got %b want 1", bus.if_gnt);
        end
        tick();
        bus.if_req     = 1'b0;
        bus.d_req      = 1'b1;
        bus.d_we       = 1'b0;
        bus.d_addr     = 32'h900;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hAAAA_BBBB) begin
            errors++;
            $display("FAIL b2b_rsp got v=%b d=%h want 1/aaaabbbb",
                     bus.if_rvalid, bus.if_rdata);
        end
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b1 ||
            bus.mem_addr !== 32'h900) begin
            errors++;
            $display("FAIL b2b_issue got g=%b en=%b a=%h want 1/1/900",
                     bus.d_gnt, bus.mem_en, bus.mem_addr);
        end
        tick();
        bus.d_req     = 1'b0;
        bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b1 ||
            bus.d_rdata !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL b2b_load got v=%b d=%h want 1/0123456789abcdef",
                     bus.d_rvalid, bus.d_rdata);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL to_issue got %b want 1", bus.if_gnt);
        end
        tick();
        bus.if_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || bus.if_rvalid !== 1'b0 ||
                bus.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL to_wait%0d got err=%b v=%b en=%b want 0",
                         k, err, bus.if_rvalid, bus.mem_en);
            end
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hFFFF_0000_FFFF_0000;
        bus.d_req      = 1'b1;
        bus.d_we       = 1'b0;
        bus.d_addr     = 32'h500;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL to_err got %b want 1", err);
        end
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 ||
            bus.d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL to_late got iv=%b dv=%b g=%b want 0/0/1",
                     bus.if_rvalid, bus.d_rvalid, bus.d_gnt);
        end
        tick();
        bus.d_req     = 1'b0;
        bus.mem_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b1 ||
            bus.d_rdata !== 64'h5555_6666_7777_8888 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_next got v=%b d=%h err=%b want 1/5555666677778888/1",
                     bus.d_rvalid, bus.d_rdata, err);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [6:0] flags;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        @(negedge clk);
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_issue got %b want 1", bus.if_gnt);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        flags = {bus.if_gnt, bus.if_rvalid, bus.d_gnt,
                 bus.d_rvalid, bus.mem_en, bus.mem_we, err};
        checks++;
        if (flags !== 7'd0 || bus.mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rm_zero got %b a=%h want 0",
                     flags, bus.mem_addr);
        end
        tick();
        reset          = 1'b0;
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h9999_8888_7777_6666;
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 ||
            bus.if_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rm_drop got iv=%b dv=%b d=%h want 0",
                     bus.if_rvalid, bus.d_rvalid, bus.if_rdata);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tinker_mem_arbiter.md
# tinker_mem_arbiter

Sequencer/arbiter that shares one single-ported 64-bit memory port between the Tinker instruction-fetch requester and the load/store requester. Holds one transaction in flight, routes the response back to its owner, and reports hung transactions through a timeout watchdog. Sits between the core's fetch/data interfaces and the memory block, replacing the separate fetch/load/store ports.

## Interface
- ADDR_W, 32, byte address width
- TIMEOUT, 255, max cycles in ARB_WAIT before abort; 8-bit counter, legal 1..255
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  32  instruction = mem_rdata[63:32]
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data / store ack (1-cycle pulse)
- d_rdata  out  64  load data = mem_rdata
- mem_en  out  1  issue strobe to memory
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  issued address
- mem_wdata  out  64  issued write data; 0 for fetch
- mem_rvalid  in  1  memory completion (read data or write ack)
- mem_rdata  in  64  memory read data, big-endian
- err  out  1  sticky timeout flag

## Operation
- States: ARB_IDLE (no transaction outstanding), ARB_WAIT (one outstanding; owner register = FETCH or DATA).
- Issue point is ARB_IDLE, or ARB_WAIT in the same cycle as mem_rvalid. At an issue point with any req: pick a winner, pulse its gnt, drive mem_en=1 with the winner's addr/we/wdata, load the owner, clear the watchdog, and go to ARB_WAIT. With no req, go to ARB_IDLE.
- Pick: fixed priority, data over fetch (see Configuration).
- In ARB_WAIT with mem_rvalid: pulse the owner's rvalid and pass mem_rdata through combinationally (fetch gets the upper word). A new issue is allowed in the same cycle, and the completing requester competes normally.
- mem_rvalid in ARB_IDLE is ignored and produces no rvalid.
- Watchdog: increments each ARB_WAIT cycle without mem_rvalid. When count == TIMEOUT, go to ARB_IDLE, set err, and emit no rvalid. A later late mem_rvalid is dropped. err clears only on reset.
- The non-winning requester keeps its req asserted and receives no gnt. Its address is not sampled.

## Timing
- Reset values: all outputs 0, state ARB_IDLE, owner NONE, watchdog 0, round-robin pointer = "last served FETCH" (data wins first).
- gnt and mem_en are combinational from req and state, in the same cycle. Owner and state are registered.
- Minimum latency: issue at cycle N, mem_rvalid at N+1, rvalid at N+1. Sustained throughput is 1 transaction/cycle when memory answers in 1 cycle.
- Reset asserted mid-transaction: immediate return to reset values. A pending response is lost, and requesters re-request after reset.
- Only gnt, rvalid and mem_en are pulses. Data outputs are 0 whenever their valid is low.

## Configuration
- TINKER_ARB_RR_EN defined: round-robin. With both requesting, the requester not served at the last issue wins, and the pointer updates on every issue. A lone requester always wins.
- Undefined: fixed priority, data over fetch. Fetch can starve under continuous d_req, by design, because the core never holds d_req longer than one instruction.

## Structure
- Package tinker_arb_pkg:
  - arb_state_t {ARB_IDLE, ARB_WAIT}
  - arb_owner_t {OWN_NONE, OWN_FETCH, OWN_DATA}
  - localparam WDOG_W = 8
- Sub-module tinker_arb_pick: combinational winner select from (if_req, d_req, last_owner), containing the TINKER_ARB_RR_EN switch.
- The top level holds the FSM, owner register, watchdog, round-robin pointer and output muxing.

## Test plan
- Reset, then if_req with if_addr=0x2000 and 1-cycle memory returning 0x1234_5678_9ABC_DEF0. Expect if_gnt and mem_en at N with mem_addr=0x2000, and if_rvalid at N+1 with if_rdata=0x1234_5678.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF_0000_0001. Expect mem_we=1 and mem_wdata equal to the store data on the issue cycle, then d_rvalid on ack.
- Simultaneous if_req and d_req held for 4 transactions:
  - Without the macro: D,D,D,D while d_req stays high.
  - With TINKER_ARB_RR_EN: D,F,D,F.
- Back-to-back: a new req during the cycle of mem_rvalid is granted in that same cycle, with no idle bubble.
- Memory never responds, TIMEOUT=4: err rises 4 cycles after issue, no rvalid, and the next req is granted. A late mem_rvalid is ignored.
- Reset asserted during ARB_WAIT: all outputs go to 0 immediately, and a mem_rvalid after reset deasserts produces no rvalid.
